// File: rtl/lau_pkg.sv
// Shared types for the lau arithmetic library: adder speed selection and
// the sequential adder's FSM state encoding.
package lau_pkg;

  typedef enum logic [1:0] {
    SLOW,
    MEDIUM,
    FAST
  } speed_e;

  typedef enum logic [1:0] {
    ADDSEQ_IDLE,
    ADDSEQ_RUN,
    ADDSEQ_DONE
  } addseq_state_e;

endpackage

// File: rtl/AddV.sv
// Combinational slice adder: S = A + B + CI with signed overflow V.
// FAST maps to a plain vector add; other speeds build an explicit ripple chain.
module AddV
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic [width-1:0] S,
  output logic             V
);

  generate
    if (speed == FAST) begin : g_fast
      logic [width:0] sum;
      logic           c_msb;
      assign sum   = {1'b0, A} + {1'b0, B} + {{width{1'b0}}, CI};
      assign S     = sum[width-1:0];
      // Carry into the MSB is recovered from the sum bit itself.
      assign c_msb = sum[width-1] ^ A[width-1] ^ B[width-1];
      assign V     = sum[width] ^ c_msb;
    end else begin : g_ripple
      logic [width:0] c;
      always_comb begin
        c    = '0;
        S    = '0;
        c[0] = CI;
        for (int i = 0; i < width; i++) begin
          S[i]   = A[i] ^ B[i] ^ c[i];
          c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
        end
      end
      assign V = c[width] ^ c[width-1];
    end
  endgenerate

endmodule

// File: rtl/lau_add_seq.sv
// Multi-cycle wide adder: one `slice`-bit segment per cycle, LSB first, carry
// chained in a register. Signed overflow is built only with LAU_ADDSEQ_OVF_EN.
module lau_add_seq
  import lau_pkg::*;
#(
  parameter int     width = 32,
  parameter int     slice = 8,
  parameter speed_e speed = FAST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] S,
  output logic             V,
  output logic             busy_o
);

  localparam int NSLICE = width / slice;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; ready/valid here are decoded from state only.
  addseq_state_e state_q, state_d;

  logic [width-1:0] a_q, b_q, s_q, s_next;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last_slice;

  logic [slice-1:0] slice_s;
  logic             slice_v;
  logic             a_msb, b_msb, c_msb, slice_co;

  AddV #(.width(slice), .speed(speed)) u_addv (
    .A  (a_q[slice-1:0]),
    .B  (b_q[slice-1:0]),
    .CI (carry_q),
    .S  (slice_s),
    .V  (slice_v)
  );

  assign a_msb      = a_q[slice-1];
  assign b_msb      = b_q[slice-1];
  assign c_msb      = slice_s[slice-1] ^ a_msb ^ b_msb;
  assign slice_co   = (a_msb & b_msb) | (a_msb & c_msb) | (b_msb & c_msb);
  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  generate
    if (NSLICE == 1) begin : g_one
      assign s_next = slice_s;
    end else begin : g_many
      assign s_next = {slice_s, s_q[width-1:slice]};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ADDSEQ_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ADDSEQ_IDLE: if (in_valid_i)  state_d = ADDSEQ_RUN;
      ADDSEQ_RUN:  if (last_slice)  state_d = ADDSEQ_DONE;
      ADDSEQ_DONE: if (out_ready_i) state_d = ADDSEQ_IDLE;
      default:                      state_d = ADDSEQ_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ADDSEQ_IDLE);
    out_valid_o = (state_q == ADDSEQ_DONE);
    busy_o      = (state_q != ADDSEQ_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ADDSEQ_IDLE: begin
          if (in_valid_i) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= CI;
            cnt_q   <= '0;
          end
        end
        ADDSEQ_RUN: begin
          a_q     <= a_q >> slice;
          b_q     <= b_q >> slice;
          s_q     <= s_next;
          carry_q <= slice_co;
          if (!last_slice) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign S = s_q;

`ifdef LAU_ADDSEQ_OVF_EN
  logic v_q;
  // Only the top slice's overflow describes the full-width signed result.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                       v_q <= 1'b0;
    else if (state_q == ADDSEQ_RUN && last_slice)    v_q <= slice_v;
  end
  assign V = v_q;
`else
  logic unused_slice_v;
  assign unused_slice_v = slice_v;
  assign V = 1'b0;
`endif

endmodule

// File: tb/tb_lau_add_seq.sv
// Self-checking bench for lau_add_seq (width 32, slice 8): directed cases plus
// randomized operations against an arithmetic reference model.
module tb_lau_add_seq;
  import lau_pkg::*;

  localparam int W  = 32;
  localparam int SL = 8;
  localparam int NS = W / SL;
  localparam longint MAXP = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint MINN = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, ci, out_valid, out_ready, v, busy;
  logic [W-1:0] a, b, s;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] exp_q[$];

  lau_add_seq #(.width(W), .slice(SL), .speed(FAST)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .A           (a),
    .B           (b),
    .CI          (ci),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .S           (s),
    .V           (v),
    .busy_o      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed sum in 64-bit arithmetic, result is its low W bits.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    longint       r;
    logic [W-1:0] sum;
    logic         ov;
    r   = longint'($signed(x)) + longint'($signed(y)) + (c ? 64'sd1 : 64'sd0);
    sum = x + y + {{(W-1){1'b0}}, c};
    ov  = (r > MAXP) || (r < MINN);
`ifndef LAU_ADDSEQ_OVF_EN
    ov  = 1'b0;
`endif
    return {ov, sum};
  endfunction

  // driver: one full operation, optionally stalling the output for `hold` cycles
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci,
                        input int hold);
    logic [W:0]   e;
    logic [W-1:0] s_hold;
    int           lat;
    exp_q.push_back(model(oa, ob, oci));
    lat = 0;
    while (!in_ready && lat < 20) begin tick(); lat++; end
    check("in_ready_idle", in_ready, 1);
    a = oa; b = ob; ci = oci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
    check("busy_run", busy, 1);
    check("in_ready_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check("latency", lat, NS);
    s_hold = s;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      tick();
      check("s_stable", s, s_hold);
      check("in_ready_done", in_ready, 0);
      check("out_valid_hold", out_valid, 1);
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check("sum", s, e[W-1:0]);
    check("ovf", v, e[W]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_clr", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("busy_idle", busy, 0);
  endtask

  task automatic reset_mid_run;
    a = 32'h0000_0002; b = 32'h0000_0003; ci = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_s", s, 0);
    check("rst_v", v, 0);
  endtask

  initial begin
    logic [W-1:0] specials[6];
    logic [W-1:0] ra, rb;
    specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h7FFF_FFFF; specials[3] = 32'h8000_0000;
    specials[4] = 32'h0000_00FF; specials[5] = 32'h00FF_FF00;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    tick(); tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_s", s, 0);
    check("reset_v", v, 0);
    rst = 1'b0;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0FED_CBA8, 1'b0, 5);
    reset_mid_run();
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1);

    for (int k = 0; k < 40; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
